// File: rtl/down_counter_pkg.sv
// Shared definitions for the chapter counter/timer designs.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/down_counter_magnitude_cmp.sv
// Unsigned magnitude compare, purely combinational: gt = (a > b).
module magnitude_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  assign gt = (a > b);

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter/timer with optional auto-reload, one-cycle underflow pulse
// and a combinational threshold compare on the registered count.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CLR,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             EN,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] counter,
  output logic             UF,
  output logic             busy,
  output logic             done,
  output logic             above
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             uf_q, uf_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    uf_d     = 1'b0;

    if (CLR) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        RUN: begin
          if (EN) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (auto_reload) begin
              // Underflow edge: the count was already 0 for one cycle.
              cnt_d = reload_q;
              uf_d  = 1'b1;
            end else begin
              uf_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      uf_q     <= uf_d;
    end
  end

  assign counter = cnt_q;
  assign UF      = uf_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

  magnitude_cmp #(
    .WIDTH(WIDTH)
  ) u_above_cmp (
    .a  (cnt_q),
    .b  (threshold),
    .gt (above)
  );

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter/timer with optional auto-reload, underflow flag and threshold compare.
- Counts in the opposite direction to the existing 8-bit up-counter and uses the same EN/CLR semantics.
- Sits next to that up-counter in the chapter test designs as a timeout/interval generator.
- Its count value feeds a magnitude compare against a programmable threshold.

Parameters:
- WIDTH, 8, bit width of count, load value, reload register and threshold.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- CLR  input  1  synchronous clear; highest priority after reset.
- load  input  1  load strobe; captures load_val into count and reload register.
- load_val  input  WIDTH  value captured on load.
- EN  input  1  count enable; decrements only while in RUN.
- auto_reload  input  1  1 = reload on underflow; 0 = stop in DONE on underflow.
- threshold  input  WIDTH  compare value for the above output.
- counter  output  WIDTH  registered current count.
- UF  output  1  registered underflow pulse, one cycle wide.
- busy  output  1  high while state = RUN.
- done  output  1  high while state = DONE.
- above  output  1  combinational; counter > threshold, unsigned.

Behaviour:
- Reset (reset=0 at rising edge): counter=0, reload_reg=0, UF=0, state=IDLE, so busy=0 and done=0. This applies mid-operation, overriding every other input.
- Input priority on each edge: reset > CLR > load > EN.
- CLR: counter=0, UF=0, state=IDLE; reload_reg is kept.
- load, any state:
  - counter=load_val and reload_reg=load_val, visible the cycle after the edge.
  - UF=0.
  - state=RUN if load_val!=0; otherwise state=DONE.
  - A load in RUN restarts the count with no underflow.
- States:
  - IDLE: counter holds; EN ignored.
  - RUN with EN=1 and counter!=0: counter<=counter-1.
  - RUN with EN=1, counter==0, auto_reload=1: counter<=reload_reg, UF<=1, stay RUN.
  - RUN with EN=1, counter==0, auto_reload=0: counter stays 0, UF<=1, state<=DONE.
  - RUN with EN=0: counter and state hold.
  - DONE: counter holds at 0; EN ignored; exits only via load, CLR or reset.
- Cycle timing:
  - Reaching 0 does not raise UF. UF is raised on the next enabled edge, when counter is at 0.
  - Period with auto_reload and EN held high is reload_reg+1 cycles.
- UF is high for exactly one cycle per underflow event; it is cleared on any edge without an underflow.
- Arithmetic: unsigned modulo 2^WIDTH; a decrement from 0 never occurs (handled by the reload/stop rules above).
- Reload of 0 with auto_reload=1 cannot occur, because loading 0 goes directly to DONE.
- EN and load in the same cycle: load wins; no decrement that cycle.
- auto_reload is sampled only on the underflow edge.

Decomposition:
- Shared package (chapter-wide):
  - state enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default WIDTH=8.
- One sub-module: magnitude_cmp (WIDTH-bit unsigned a>b, combinational), instantiated for the above output.
- The state register and counter datapath stay in down_counter.

Test Plan:
- Reset: reset=0 for 2 edges, then release -> counter=0, UF=0, busy=0, done=0; EN=1 alone leaves counter at 0 in IDLE.
- One-shot: load=1, load_val=3, auto_reload=0, then EN=1 -> counter 3,2,1,0 on successive cycles; next edge UF=1 for one cycle, done=1, busy=0, counter stays 0.
- Auto-reload: load_val=2, auto_reload=1, EN=1 for 9 cycles:
  - counter sequence 2,1,0,2,1,0,2,1,0.
  - UF pulses coincide with each return to 2; busy stays 1.
- Priority/mid-run: in RUN at counter=5, assert load (load_val=8) and EN together -> counter=8, no decrement, UF=0. Next cycle assert CLR and load together -> counter=0, state IDLE.
- Pause and threshold: threshold=4, load_val=6, EN toggled 1,0,1 -> counter 6,5,5,4; above=1,1,1,0.
- Reset mid-operation and zero load:
  - reset=0 while in RUN at counter=7 -> next cycle counter=0, state IDLE, UF=0.
  - load_val=0 -> done=1 immediately, UF never asserted.
